// File: rtl/vdot_exec_unit_if.sv
// vdot_exec_unit_if: issue/writeback handshake and data-memory read port of the VDOT unit.
// master = issuing pipeline stage plus data memory, slave = the execution unit.
interface vdot_exec_unit_if #(
  parameter int LEN_W = 6
);
  logic             start;
  logic [LEN_W-1:0] vlen;
  logic [31:0]      base_a;
  logic [31:0]      base_b;
  logic [31:0]      acc_init;
  logic [4:0]       rd_in;
  logic             stall;
  logic             done;
  logic [31:0]      result;
  logic [4:0]       rd_out;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_ready;
  logic [31:0]      mem_rdata;

  modport master (
    output start, vlen, base_a, base_b, acc_init, rd_in, mem_ready, mem_rdata,
    input  stall, done, result, rd_out, mem_req, mem_addr
  );

  modport slave (
    input  start, vlen, base_a, base_b, acc_init, rd_in, mem_ready, mem_rdata,
    output stall, done, result, rd_out, mem_req, mem_addr
  );
endinterface

// File: rtl/vdot_exec_unit.sv
// vdot_exec_unit: multi-cycle signed int8x4 dot-product accumulate for the VDOT instruction.
// Define VDOT_SAT_EN to saturate each accumulate to signed 32-bit instead of wrapping.

module vdot_lane_mul (
  input  logic [7:0]         a_i,
  input  logic [7:0]         b_i,
  output logic signed [15:0] p_o
);
  assign p_o = $signed(a_i) * $signed(b_i);
endmodule

module vdot_exec_unit #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  vdot_exec_unit_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_MAC, S_DONE} state_t;

  state_t            state_q;
  logic [31:0]       a_q, b_q, acc_q, wa_q, wb_q;
  logic [31:0]       result_q, mem_addr_q;
  logic [CNT_W-1:0]  len_q, i_q;
  logic [4:0]        rd_q, rd_out_q;
  logic              done_q, mem_req_q;

  logic [LEN_W-1:0]  vlen_w;
  logic [CNT_W-1:0]  len_d, i_nxt;
  logic [31:0]       addr_b_cur, addr_a_nxt, acc_nxt;
  logic [NUM_LANES-1:0][15:0] prod;
  logic signed [17:0] lane_sum;

  assign vlen_w = bus.vlen;
  assign len_d  = (32'(vlen_w) > MAX_LEN) ? CNT_W'(MAX_LEN) : CNT_W'(vlen_w);
  assign i_nxt  = i_q + 1'b1;

  // Word-aligned addresses; the adds wrap naturally at 2^32.
  assign addr_b_cur = (b_q + 32'({i_q, 2'b00}))   & ~32'h3;
  assign addr_a_nxt = (a_q + 32'({i_nxt, 2'b00})) & ~32'h3;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    vdot_lane_mul u_mul (
      .a_i (wa_q[8*k +: 8]),
      .b_i (wb_q[8*k +: 8]),
      .p_o (prod[k])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < NUM_LANES; k++)
      lane_sum = lane_sum + 18'($signed(prod[k]));
  end

`ifdef VDOT_SAT_EN
  logic [32:0] acc_sum;
  assign acc_sum = {acc_q[31], acc_q} + {{15{lane_sum[17]}}, lane_sum};
  // Sign bits 32 and 31 disagree only on signed overflow; bit 32 is the true sign.
  assign acc_nxt = (acc_sum[32] != acc_sum[31])
                 ? (acc_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                 : acc_sum[31:0];
`else
  assign acc_nxt = acc_q + {{14{lane_sum[17]}}, lane_sum};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      wa_q       <= '0;
      wb_q       <= '0;
      len_q      <= '0;
      i_q        <= '0;
      rd_q       <= '0;
      rd_out_q   <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_q   <= bus.base_a;
            b_q   <= bus.base_b;
            acc_q <= bus.acc_init;
            rd_q  <= bus.rd_in;
            len_q <= len_d;
            i_q   <= '0;
            if (len_d == '0) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= bus.acc_init;
              rd_out_q <= bus.rd_in;
            end else begin
              state_q    <= S_RD_A;
              mem_req_q  <= 1'b1;
              mem_addr_q <= bus.base_a & ~32'h3;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RD_A: if (bus.mem_ready) begin
          wa_q       <= bus.mem_rdata;
          mem_addr_q <= addr_b_cur;
          state_q    <= S_RD_B;
        end
        S_RD_B: if (bus.mem_ready) begin
          wb_q      <= bus.mem_rdata;
          mem_req_q <= 1'b0;
          state_q   <= S_MAC;
        end
        S_MAC: begin
          acc_q <= acc_nxt;
          i_q   <= i_nxt;
          if (i_nxt == len_q) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= acc_nxt;
            rd_out_q <= rd_q;
          end else begin
            state_q    <= S_RD_A;
            mem_req_q  <= 1'b1;
            mem_addr_q <= addr_a_nxt;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.stall    = (((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start) ||
                        (state_q == S_RD_A) || (state_q == S_RD_B) || (state_q == S_MAC);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.rd_out   = rd_out_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_vdot_exec_unit.sv
// tb_vdot_exec_unit: directed vector table, multi-cycle corner sequences and randomized ops
// checked against a plain-arithmetic dot-product model over a sparse word memory.
module tb_vdot_exec_unit;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
  localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint SMIN = -64'sh0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vdot_exec_unit_if #(.LEN_W(LEN_W)) bus ();

  vdot_exec_unit #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [LEN_W-1:0] vlen;
    logic [31:0]      base_a;
    logic [31:0]      base_b;
    logic [31:0]      acc;
    logic [4:0]       rd;
    logic [1:0][31:0] wa;
    logic [1:0][31:0] wb;
    logic [31:0]      exp_res;
    int               exp_cyc;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] mem [bit [31:0]];
  int wq[$];
  logic [31:0] a_seen[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] addr);
    logic [31:0] w;
    w = {addr[31:2], 2'b00};
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  function automatic int clamp_len(input logic [LEN_W-1:0] v);
    return (int'(v) > MAX_LEN) ? MAX_LEN : int'(v);
  endfunction

  // Reference: signed byte-lane dot products accumulated word by word.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] acc0, input int len);
    logic [31:0] r, wa, wb;
    longint s, t;
    r = acc0;
    for (int j = 0; j < len; j++) begin
      wa = rd_mem(a + 32'(4*j));
      wb = rd_mem(b + 32'(4*j));
      s = 0;
      for (int k = 0; k < 4; k++)
        s += longint'($signed(wa[8*k +: 8])) * longint'($signed(wb[8*k +: 8]));
`ifdef VDOT_SAT_EN
      t = longint'($signed(r)) + s;
      if (t > SMAX) t = SMAX;
      else if (t < SMIN) t = SMIN;
      r = t[31:0];
`else
      t = s;
      r = r + t[31:0];
`endif
    end
    return r;
  endfunction

  // Issues at the current negedge and returns at the negedge where done is seen.
  task automatic run_op(input string tag, input logic [LEN_W-1:0] vlen, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] acc, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_cyc);
    int L, cyc, wait_left, phase, nreads, stable_bad, stall_bad, addr_bad;
    bit in_req;
    logic [31:0] last_addr;
    L = clamp_len(vlen);
    cyc = 1; wait_left = 0; phase = 0; nreads = 0;
    stable_bad = 0; stall_bad = 0; addr_bad = 0; in_req = 0; last_addr = '0;
    a_seen.delete();
    bus.start = 1'b1; bus.vlen = vlen; bus.base_a = a; bus.base_b = b;
    bus.acc_init = acc; bus.rd_in = rd; bus.mem_ready = 1'b0;
    #1 chk({tag, " stall_on_issue"}, 64'(bus.stall), 64'd1);
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0; bus.vlen = LEN_W'($urandom); bus.base_a = $urandom;
    bus.base_b = $urandom; bus.acc_init = $urandom; bus.rd_in = 5'($urandom);
    while (cyc <= 400 && !bus.done) begin
      if (!bus.stall) stall_bad++;
      if (bus.mem_req) begin
        if (!in_req) begin
          in_req = 1; last_addr = bus.mem_addr;
          wait_left = (wq.size() > 0) ? wq.pop_front() : 0;
          if (phase == 0) a_seen.push_back(bus.mem_addr);
        end else if (bus.mem_addr !== last_addr) stable_bad++;
        bus.mem_ready = (wait_left == 0);
        bus.mem_rdata = (wait_left == 0) ? rd_mem(bus.mem_addr) : $urandom;
        if (wait_left == 0) begin in_req = 0; nreads++; phase ^= 1; end
        else wait_left--;
      end else begin
        if (in_req) stable_bad++;
        in_req = 0;
        bus.mem_ready = 1'b0; bus.mem_rdata = $urandom;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    bus.mem_ready = 1'b0;
    for (int j = 0; j < a_seen.size(); j++)
      if (a_seen[j] !== ((a + 32'(4*j)) & ~32'h3)) addr_bad++;
    chk({tag, " done_seen"}, 64'(bus.done), 64'd1);
    chk({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, " result"}, 64'(bus.result), 64'(exp_res));
    chk({tag, " rd_out"}, 64'(bus.rd_out), 64'(rd));
    chk({tag, " reads"}, 64'(nreads), 64'(2*L));
    chk({tag, " req_stable"}, 64'(stable_bad), 64'd0);
    chk({tag, " stall_busy"}, 64'(stall_bad), 64'd0);
    chk({tag, " a_addrs"}, 64'(addr_bad), 64'd0);
  endtask

  task automatic idle_chk(input string tag);
    bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  vec_t tbl[5];

  initial begin
    int L, tw;
    logic [31:0] a, b, acc, exp;
    logic [LEN_W-1:0] vl;
    bus.start = 1'b0; bus.vlen = '0; bus.base_a = '0; bus.base_b = '0;
    bus.acc_init = '0; bus.rd_in = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;

    tbl[0] = '{6'd1, 32'h1000, 32'h2000, 32'h0, 5'd7,
               {32'h0, 32'h0403_0201}, {32'h0, 32'h0101_0101}, 32'd10, 4};
    tbl[1] = '{6'd2, 32'h0100, 32'h0200, 32'd5, 5'd19,
               {32'h0000_0002, 32'hFF80_FF80}, {32'h0000_0003, 32'h8080_8080}, 32'd33035, 7};
    tbl[2] = '{6'd0, 32'h3000, 32'h4000, 32'hDEAD_BEEF, 5'd31,
               {32'h0, 32'h0}, {32'h0, 32'h0}, 32'hDEAD_BEEF, 1};
`ifdef VDOT_SAT_EN
    tbl[3] = '{6'd1, 32'h5000, 32'h6000, 32'h7FFF_FF00, 5'd1,
               {32'h0, 32'h0000_0010}, {32'h0, 32'h0000_0020}, 32'h7FFF_FFFF, 4};
    tbl[4] = '{6'd1, 32'h7000, 32'h8000, 32'h8000_0010, 5'd2,
               {32'h0, 32'h8080_8080}, {32'h0, 32'h7F7F_7F7F}, 32'h8000_0000, 4};
`else
    tbl[3] = '{6'd1, 32'h5000, 32'h6000, 32'h7FFF_FF00, 5'd1,
               {32'h0, 32'h0000_0010}, {32'h0, 32'h0000_0020}, 32'h8000_0100, 4};
    tbl[4] = '{6'd1, 32'h7000, 32'h8000, 32'h8000_0010, 5'd2,
               {32'h0, 32'h8080_8080}, {32'h0, 32'h7F7F_7F7F}, 32'h7FFF_0210, 4};
`endif

    repeat (2) @(negedge clk);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset result", 64'(bus.result), 64'd0);
    chk("reset rd_out", 64'(bus.rd_out), 64'd0);
    chk("reset mem_req", 64'(bus.mem_req), 64'd0);
    chk("reset mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("reset stall", 64'(bus.stall), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 5; n++) begin
      for (int j = 0; j < 2; j++) begin
        mem[tbl[n].base_a + 32'(4*j)] = tbl[n].wa[j];
        mem[tbl[n].base_b + 32'(4*j)] = tbl[n].wb[j];
      end
      wq.delete();
      run_op($sformatf("vec%0d", n), tbl[n].vlen, tbl[n].base_a, tbl[n].base_b,
             tbl[n].acc, tbl[n].rd, tbl[n].exp_res, tbl[n].exp_cyc);
      idle_chk($sformatf("vec%0d", n));
    end

    // Wait states: 2 cycles on A, 1 on B.
    mem[32'h40] = 32'h0403_0201; mem[32'h80] = 32'h0101_0101;
    wq.delete(); wq.push_back(2); wq.push_back(1);
    run_op("waits", 6'd1, 32'h40, 32'h80, 32'h0, 5'd9, 32'd10, 7);
    idle_chk("waits");

    // Address wrap past 2^32.
    wq.delete();
    exp = model(32'hFFFF_FFFE, 32'h9000, 32'h0, 2);
    run_op("wrap", 6'd2, 32'hFFFF_FFFE, 32'h9000, 32'h0, 5'd4, exp, 7);
    chk("wrap a_addr0", 64'(a_seen.size() > 0 ? a_seen[0] : 32'h1), 64'hFFFF_FFFC);
    chk("wrap a_addr1", 64'(a_seen.size() > 1 ? a_seen[1] : 32'h1), 64'h0);
    idle_chk("wrap");

    // Back-to-back: second start lands in the DONE cycle of the first.
    run_op("b2b0", tbl[0].vlen, tbl[0].base_a, tbl[0].base_b, tbl[0].acc, tbl[0].rd, 32'd10, 4);
    run_op("b2b1", tbl[1].vlen, tbl[1].base_a, tbl[1].base_b, tbl[1].acc, tbl[1].rd, 32'd33035, 7);
    idle_chk("b2b1");

    // Reset while waiting in RD_B.
    mem[32'h500] = 32'h1; mem[32'h600] = 32'h2;
    bus.start = 1'b1; bus.vlen = 6'd1; bus.base_a = 32'h500; bus.base_b = 32'h600;
    bus.acc_init = 32'h1; bus.rd_in = 5'd3;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    chk("rstmid rd_a addr", 64'(bus.mem_addr), 64'h500);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1;
    @(posedge clk); @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("rstmid rd_b addr", 64'(bus.mem_addr), 64'h600);
    @(posedge clk); @(negedge clk);
    chk("rstmid rd_b req", 64'(bus.mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid done", 64'(bus.done), 64'd0);
    chk("rstmid result", 64'(bus.result), 64'd0);
    chk("rstmid rd_out", 64'(bus.rd_out), 64'd0);
    chk("rstmid mem_req", 64'(bus.mem_req), 64'd0);
    chk("rstmid mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rstmid stall", 64'(bus.stall), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid idle req", 64'(bus.mem_req), 64'd0);
    run_op("post_rst", tbl[0].vlen, tbl[0].base_a, tbl[0].base_b, tbl[0].acc, tbl[0].rd, 32'd10, 4);
    idle_chk("post_rst");

    // Length clamp: 40 words requested, 32 processed.
    wq.delete();
    exp = model(32'h10000, 32'h20000, 32'h1234_5678, MAX_LEN);
    run_op("clamp", 6'd40, 32'h10000, 32'h20000, 32'h1234_5678, 5'd12, exp, 1 + 3*MAX_LEN);
    idle_chk("clamp");

    // Randomized ops with random wait states.
    for (int n = 0; n < 20; n++) begin
      vl = LEN_W'($urandom_range(0, 40));
      a = $urandom; b = $urandom; acc = $urandom;
      L = clamp_len(vl);
      wq.delete(); tw = 0;
      for (int q = 0; q < 2*L; q++) begin
        int w;
        w = $urandom_range(0, 2);
        wq.push_back(w); tw += w;
      end
      exp = model(a, b, acc, L);
      run_op($sformatf("rand%0d", n), vl, a, b, acc, 5'($urandom), exp,
             (L == 0) ? 1 : 1 + 3*L + tw);
      if ($urandom_range(0, 1) == 1) idle_chk($sformatf("rand%0d", n));
    end
    idle_chk("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
